// File: rtl/pll_reset_sequencer_pkg.sv
// Shared definitions for the PLL lock / J1 core reset sequencer.
// State encodings double as the seqState debug/LED value.
package pll_reset_sequencer_pkg;

    localparam int SEQ_STATE_W = 2;

    typedef enum logic [SEQ_STATE_W-1:0] {
        ST_WAIT_LOCK = 2'd0,
        ST_STABLE    = 2'd1,
        ST_HOLD      = 2'd2,
        ST_RUN       = 2'd3
    } seq_state_e;

endpackage

// File: rtl/pll_reset_sequencer_if.sv
// Signal bundle between the PLL/board side (master) and the reset sequencer (slave).
interface pll_reset_sequencer_if
    import pll_reset_sequencer_pkg::*;
#(
    parameter int LOSS_WIDTH = 8
) ();

    logic                   isLocked;
    logic                   extResetN;
    logic                   coreReset;
    logic                   coreReady;
    logic [LOSS_WIDTH-1:0]  lockLossCount;
    logic [SEQ_STATE_W-1:0] seqState;

    modport master (
        output isLocked, extResetN,
        input  coreReset, coreReady, lockLossCount, seqState
    );

    modport slave (
        input  isLocked, extResetN,
        output coreReset, coreReady, lockLossCount, seqState
    );

endinterface

// File: rtl/pll_reset_sequencer_sync_2ff.sv
// Two-flop synchroniser for a single asynchronous level; clears to 0 on reset.
module sync_2ff (
    input  logic clk,
    input  logic resetN,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/pll_reset_sequencer.sv
// Waits for a stable PLL lock, holds the J1 core in reset for a fixed time, then releases it;
// any lock loss or button press restarts the sequence immediately.
module pll_reset_sequencer
    import pll_reset_sequencer_pkg::*;
#(
    parameter int LOCK_CYCLES = 1024,
    parameter int HOLD_CYCLES = 16,
    parameter int CNT_WIDTH   = 16,
    parameter int LOSS_WIDTH  = 8
) (
    input  logic                        clk,
    input  logic                        resetN,
    pll_reset_sequencer_if.slave        bus
);

    localparam logic [CNT_WIDTH-1:0]  LOCK_LAST = CNT_WIDTH'(LOCK_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0]  HOLD_LAST = CNT_WIDTH'(HOLD_CYCLES - 1);
    localparam logic [LOSS_WIDTH-1:0] LOSS_MAX  = '1;

    logic                  w_lock_s;
    logic                  w_ext_s;
    logic                  w_lock_ok;
    seq_state_e            w_next_state;
    logic [CNT_WIDTH-1:0]  w_next_cnt;

    seq_state_e            r_state;
    logic [CNT_WIDTH-1:0]  r_cnt;
    logic                  r_core_reset;
    logic                  r_core_ready;
    logic [LOSS_WIDTH-1:0] r_loss_cnt;

    sync_2ff u_sync_lock (.clk(clk), .resetN(resetN), .i_d(bus.isLocked),  .o_q(w_lock_s));
    sync_2ff u_sync_ext  (.clk(clk), .resetN(resetN), .i_d(bus.extResetN), .o_q(w_ext_s));

    assign w_lock_ok = w_lock_s & w_ext_s;

    // NOTE: defaults first so every path assigns every output and no latch is inferred.
    always_comb begin
        w_next_state = r_state;
        w_next_cnt   = r_cnt;
        if (!w_lock_ok) begin
            // Losing lock or the button wins over any terminal count.
            w_next_state = ST_WAIT_LOCK;
            w_next_cnt   = '0;
        end else begin
            unique case (r_state)
                ST_WAIT_LOCK: begin
                    w_next_state = ST_STABLE;
                    w_next_cnt   = '0;
                end
                ST_STABLE: begin
                    if (r_cnt == LOCK_LAST) begin
                        w_next_state = ST_HOLD;
                        w_next_cnt   = '0;
                    end else begin
                        w_next_cnt = r_cnt + 1'b1;
                    end
                end
                ST_HOLD: begin
                    if (r_cnt == HOLD_LAST) begin
                        w_next_state = ST_RUN;
                        w_next_cnt   = '0;
                    end else begin
                        w_next_cnt = r_cnt + 1'b1;
                    end
                end
                ST_RUN: w_next_cnt = '0;
                default: begin
                    w_next_state = ST_WAIT_LOCK;
                    w_next_cnt   = '0;
                end
            endcase
        end
    end

    // Outputs are registered from the next state so they change on the same edge as the state.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_state      <= ST_WAIT_LOCK;
            r_cnt        <= '0;
            r_core_reset <= 1'b1;
            r_core_ready <= 1'b0;
            r_loss_cnt   <= '0;
        end else begin
            r_state      <= w_next_state;
            r_cnt        <= w_next_cnt;
            r_core_reset <= (w_next_state != ST_RUN);
            r_core_ready <= (w_next_state == ST_RUN);
            // Only a PLL drop out of RUN counts; button exits are ignored.
            if (r_state == ST_RUN && !w_lock_s && r_loss_cnt != LOSS_MAX) begin
                r_loss_cnt <= r_loss_cnt + 1'b1;
            end
        end
    end

    assign bus.coreReset     = r_core_reset;
    assign bus.coreReady     = r_core_ready;
    assign bus.lockLossCount = r_loss_cnt;
    assign bus.seqState      = r_state;

endmodule
